register_file_r7: RTL and testbench
===================================

Name: register_file_r7

Overview:
- Eight-entry, 16-bit architectural register file. It is the receiving end of the write-back stage's outputs: GPR write address/data/enable, plus the dedicated R7 (program counter) value.
- Serves two combinational read ports to the register-read stage and exposes the current PC to fetch.
- Holds a per-register pending-write scoreboard so the hazard unit can stall consumers until write-back retires the producer.

Parameters:
- DATA_W, 16, register and port data width
- BYPASS, 1, 1 = same-cycle write-to-read forwarding of GPR write data; 0 = reads show only stored state
- R7_RESET, 16'h0000, PC value loaded into R7 on reset

Ports:
- clk  input  1  system clock, all state updates on rising edge
- reset  input  1  synchronous, active-high; all state takes its reset value at the next rising edge
- rf_a1  input  3  read port 1 address
- rf_a2  input  3  read port 2 address
- rf_d1  output  DATA_W  read port 1 data
- rf_d2  output  DATA_W  read port 2 data
- rf_a3_in  input  3  GPR write address from write-back
- rf_d3_in  input  DATA_W  GPR write data from write-back
- rf_d3_write_wb_in  input  1  GPR write enable from write-back (already forced 0 by write-back on R7 writes)
- d_R7_in  input  DATA_W  next R7 value from write-back (updated PC or write-back data)
- r7_write_en  input  1  load R7 from d_R7_in this cycle (deasserted during pipeline stall)
- pc_out  output  DATA_W  current R7 contents
- sb_reserve_en  input  1  decode marks a destination register pending
- sb_reserve_addr  input  3  destination being reserved
- busy1  output  1  rf_a1 has an outstanding write
- busy2  output  1  rf_a2 has an outstanding write

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-high on reset. A reset in mid-operation discards same-cycle writes and reservations; reset has priority over everything.
- Reset values:
  - R0..R6 = 0.
  - R7 = R7_RESET.
  - Scoreboard = all 0, so busy1 and busy2 = 0.
  - pc_out = R7_RESET.
  - rf_d1 and rf_d2 reflect the reset contents.
- GPR write: on the rising edge with rf_d3_write_wb_in=1 and rf_a3_in in 0..6, Rn <= rf_d3_in.
  - rf_a3_in=7 with the enable high is ignored; R7 is written only through d_R7_in.
- R7 write: on the rising edge with r7_write_en=1, R7 <= d_R7_in. This is independent of the GPR write, and both may occur in the same cycle.
- Reads: combinational, zero latency.
  - Address 7 returns the stored R7 (no R7 bypass).
  - BYPASS=1: if rf_aN == rf_a3_in, rf_d3_write_wb_in=1 and rf_a3_in != 7, then rf_dN = rf_d3_in. Otherwise rf_dN = stored value.
  - Both ports may read the same address simultaneously.
- Scoreboard: 7 pending bits, one each for R0..R6.
  - Set: sb_reserve_en=1 and sb_reserve_addr in 0..6.
  - Clear: rf_d3_write_wb_in=1 and rf_a3_in in 0..6.
  - Set and clear of the same register in one cycle: set wins (a new producer has been issued).
  - Reserve of address 7 is ignored.
  - Writes to a register that is not pending are legal and leave the bit at 0.
- busy outputs: busyN = pending[rf_aN] for rf_aN in 0..6, and 0 for rf_aN=7.
  - BYPASS=1: busyN is masked to 0 when the same-cycle GPR write to rf_aN is forwarding, unless a reserve to that register occurs in the same cycle. Forwarded data is valid this cycle, so no stall is needed.
- Arithmetic: none. Widths are exact and there is no sign handling.

Decomposition:
- Shared package:
  - DATA_W.
  - REG_ADDR_W = 3.
  - R7_IDX = 3'd7.
  - GPR_COUNT = 7.
  - Typedef for a register address.
- One natural sub-module: rf_scoreboard (pending bits, set/clear priority, busy lookup). Storage, R7 and bypass stay in the top module.

Test Plan:
- Reset then read: assert reset 1 cycle with R7_RESET=16'h0000 -> rf_d1(a1=3)=0, pc_out=0, busy1=busy2=0.
- GPR write plus bypass: write R2=16'hBEEF with a1=2 in the same cycle -> rf_d1=16'hBEEF that cycle (BYPASS=1), and still 16'hBEEF the next cycle with the enable low. With BYPASS=0 the same-cycle read returns the old value 0.
- R7 path: r7_write_en=1 with d_R7_in=16'h0010 -> pc_out=16'h0010 next cycle. In the same cycle, a GPR write with rf_a3_in=7 and data 16'hFFFF -> R7 stays 16'h0010 and rf_d1(a1=7)=16'h0010.
- Scoreboard: reserve R5 -> busy1(a1=5)=1 on following cycles. Write-back R5=16'h1234 -> busy1=0 in the write cycle (bypass) and after it.
- Simultaneous set/clear: reserve R4 and write back R4 in the same cycle -> R4 is updated, busy for R4 remains 1 next cycle. Reserve of address 7 -> busy for a=7 stays 0.
- Reset mid-operation: with R1 pending and a write to R1 issued in the reset cycle -> after reset R1=0 and the R1 pending bit is 0.

Source files
------------

// File: rtl/register_file_r7_pkg.sv
// Shared definitions for the architectural register file and its scoreboard.
package register_file_r7_pkg;

   localparam int DATA_W     = 16;
   localparam int REG_ADDR_W = 3;
   localparam int GPR_COUNT  = 7;

   typedef logic [REG_ADDR_W-1:0] reg_addr_t;

   localparam reg_addr_t R7_IDX = 3'd7;

endpackage

// File: rtl/register_file_r7_scoreboard.sv
// Pending-write scoreboard for R0..R6: a reserve sets a bit, a write-back clears it,
// and the busy lookup can hide a register whose data is being forwarded this cycle.
module rf_scoreboard #(
   parameter bit BYPASS = 1'b1
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       reserve_en,
   input  logic [2:0] reserve_addr,
   input  logic       clear_en,
   input  logic [2:0] clear_addr,
   input  logic [2:0] a1,
   input  logic [2:0] a2,
   output logic       busy1,
   output logic       busy2
);
   import register_file_r7_pkg::*;

   logic [GPR_COUNT-1:0] pending;

   // The set is applied after the clear so a freshly issued producer wins.
   always_ff @(posedge clk) begin
      if (reset) begin
         pending <= '0;
      end else begin
         if (clear_en && (clear_addr != R7_IDX)) pending[clear_addr] <= 1'b0;
         if (reserve_en && (reserve_addr != R7_IDX)) pending[reserve_addr] <= 1'b1;
      end
   end

   function automatic logic lookup(
      input reg_addr_t            a,
      input logic [GPR_COUNT-1:0] pend,
      input logic                 clr_en,
      input reg_addr_t            clr_addr,
      input logic                 rsv_en,
      input reg_addr_t            rsv_addr
   );
      logic hit;
      logic fwd;
      logic rsv;
      hit = (a != R7_IDX) && pend[a];
      fwd = BYPASS && clr_en && (clr_addr == a) && (a != R7_IDX);
      rsv = rsv_en && (rsv_addr == a);
      return hit && !(fwd && !rsv);
   endfunction

   assign busy1 = lookup(a1, pending, clear_en, clear_addr, reserve_en, reserve_addr);
   assign busy2 = lookup(a2, pending, clear_en, clear_addr, reserve_en, reserve_addr);

endmodule

// File: rtl/register_file_r7.sv
// Eight-entry register file: R0..R6 written from write-back, R7 (PC) loaded separately,
// two combinational read ports with optional write-to-read forwarding and hazard flags.
module register_file_r7 #(
   parameter int                               DATA_W   = register_file_r7_pkg::DATA_W,
   parameter bit                               BYPASS   = 1'b1,
   parameter logic [DATA_W-1:0]                R7_RESET = '0
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [2:0]        rf_a1,
   input  logic [2:0]        rf_a2,
   output logic [DATA_W-1:0] rf_d1,
   output logic [DATA_W-1:0] rf_d2,
   input  logic [2:0]        rf_a3_in,
   input  logic [DATA_W-1:0] rf_d3_in,
   input  logic              rf_d3_write_wb_in,
   input  logic [DATA_W-1:0] d_R7_in,
   input  logic              r7_write_en,
   output logic [DATA_W-1:0] pc_out,
   input  logic              sb_reserve_en,
   input  logic [2:0]        sb_reserve_addr,
   output logic              busy1,
   output logic              busy2
);
   import register_file_r7_pkg::*;

   logic [DATA_W-1:0] gpr [GPR_COUNT];
   logic [DATA_W-1:0] r7;
   logic              gpr_we;

   // A GPR write aimed at R7 is dropped; R7 only changes through d_R7_in.
   assign gpr_we = rf_d3_write_wb_in && (rf_a3_in != R7_IDX);

   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < GPR_COUNT; i++) gpr[i] <= '0;
         r7 <= R7_RESET;
      end else begin
         if (gpr_we) gpr[rf_a3_in] <= rf_d3_in;
         if (r7_write_en) r7 <= d_R7_in;
      end
   end

   always_comb begin
      rf_d1 = (rf_a1 == R7_IDX) ? r7 : gpr[rf_a1];
      if (BYPASS && gpr_we && (rf_a1 == rf_a3_in)) rf_d1 = rf_d3_in;
   end

   always_comb begin
      rf_d2 = (rf_a2 == R7_IDX) ? r7 : gpr[rf_a2];
      if (BYPASS && gpr_we && (rf_a2 == rf_a3_in)) rf_d2 = rf_d3_in;
   end

   assign pc_out = r7;

   rf_scoreboard #(
      .BYPASS(BYPASS)
   ) u_scoreboard (
      .clk         (clk),
      .reset       (reset),
      .reserve_en  (sb_reserve_en),
      .reserve_addr(sb_reserve_addr),
      .clear_en    (rf_d3_write_wb_in),
      .clear_addr  (rf_a3_in),
      .a1          (rf_a1),
      .a2          (rf_a2),
      .busy1       (busy1),
      .busy2       (busy2)
   );

endmodule

// File: tb/tb_register_file_r7.sv
// Bench for register_file_r7: a forwarding and a non-forwarding instance share stimulus
// and are compared every cycle against an array-based model of the register file.
module tb_register_file_r7;

   localparam logic [15:0] R7_RST_N = 16'hA5C3;

   logic        clk = 1'b0;
   logic        reset;
   logic [2:0]  rf_a1, rf_a2, rf_a3_in, sb_reserve_addr;
   logic [15:0] rf_d3_in, d_R7_in;
   logic        rf_d3_write_wb_in, r7_write_en, sb_reserve_en;

   logic [15:0] d1_b, d2_b, pc_b, d1_n, d2_n, pc_n;
   logic        busy1_b, busy2_b, busy1_n, busy2_n;

   int checks = 0;
   int errors = 0;

   logic [15:0] m_reg [8];
   logic [15:0] m_r7_b, m_r7_n;
   bit          m_pend [8];

   always #5 clk = ~clk;

   register_file_r7 #(.DATA_W(16), .BYPASS(1'b1), .R7_RESET(16'h0000)) dut (
      .clk(clk), .reset(reset), .rf_a1(rf_a1), .rf_a2(rf_a2), .rf_d1(d1_b), .rf_d2(d2_b),
      .rf_a3_in(rf_a3_in), .rf_d3_in(rf_d3_in), .rf_d3_write_wb_in(rf_d3_write_wb_in),
      .d_R7_in(d_R7_in), .r7_write_en(r7_write_en), .pc_out(pc_b),
      .sb_reserve_en(sb_reserve_en), .sb_reserve_addr(sb_reserve_addr),
      .busy1(busy1_b), .busy2(busy2_b));

   register_file_r7 #(.DATA_W(16), .BYPASS(1'b0), .R7_RESET(R7_RST_N)) dut_nobyp (
      .clk(clk), .reset(reset), .rf_a1(rf_a1), .rf_a2(rf_a2), .rf_d1(d1_n), .rf_d2(d2_n),
      .rf_a3_in(rf_a3_in), .rf_d3_in(rf_d3_in), .rf_d3_write_wb_in(rf_d3_write_wb_in),
      .d_R7_in(d_R7_in), .r7_write_en(r7_write_en), .pc_out(pc_n),
      .sb_reserve_en(sb_reserve_en), .sb_reserve_addr(sb_reserve_addr),
      .busy1(busy1_n), .busy2(busy2_n));

   task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
      end
   endtask

   // Value a read port should show, given the stored model state and this cycle's inputs.
   function automatic logic [15:0] exp_rd(input logic [2:0] a, input bit byp, input logic [15:0] r7);
      if (byp && rf_d3_write_wb_in && rf_a3_in != 3'd7 && a == rf_a3_in) return rf_d3_in;
      if (a == 3'd7) return r7;
      return m_reg[a];
   endfunction

   function automatic logic [15:0] exp_busy(input logic [2:0] a, input bit byp);
      if (a == 3'd7) return 16'd0;
      if (byp && rf_d3_write_wb_in && rf_a3_in == a && !(sb_reserve_en && sb_reserve_addr == a))
         return 16'd0;
      return {15'd0, m_pend[a]};
   endfunction

   task automatic drive(input bit rst, input logic [2:0] a1, input logic [2:0] a2,
                        input bit we, input logic [2:0] a3, input logic [15:0] d3,
                        input bit r7we, input logic [15:0] d7,
                        input bit rsv, input logic [2:0] rsv_a);
      reset = rst; rf_a1 = a1; rf_a2 = a2;
      rf_d3_write_wb_in = we; rf_a3_in = a3; rf_d3_in = d3;
      r7_write_en = r7we; d_R7_in = d7;
      sb_reserve_en = rsv; sb_reserve_addr = rsv_a;
      #1;
   endtask

   task automatic check_all();
      check("d1_byp",    d1_b, exp_rd(rf_a1, 1'b1, m_r7_b));
      check("d2_byp",    d2_b, exp_rd(rf_a2, 1'b1, m_r7_b));
      check("pc_byp",    pc_b, m_r7_b);
      check("busy1_byp", {15'd0, busy1_b}, exp_busy(rf_a1, 1'b1));
      check("busy2_byp", {15'd0, busy2_b}, exp_busy(rf_a2, 1'b1));
      check("d1_nobyp",  d1_n, exp_rd(rf_a1, 1'b0, m_r7_n));
      check("d2_nobyp",  d2_n, exp_rd(rf_a2, 1'b0, m_r7_n));
      check("pc_nobyp",  pc_n, m_r7_n);
      check("busy1_nobyp", {15'd0, busy1_n}, exp_busy(rf_a1, 1'b0));
      check("busy2_nobyp", {15'd0, busy2_n}, exp_busy(rf_a2, 1'b0));
   endtask

   // Advance one clock and apply the architectural update rules to the model.
   task automatic tick();
      @(posedge clk);
      if (reset) begin
         for (int i = 0; i < 8; i++) begin
            m_reg[i] = 16'd0;
            m_pend[i] = 1'b0;
         end
         m_r7_b = 16'h0000;
         m_r7_n = R7_RST_N;
      end else begin
         if (rf_d3_write_wb_in && rf_a3_in != 3'd7) begin
            m_reg[rf_a3_in] = rf_d3_in;
            m_pend[rf_a3_in] = 1'b0;
         end
         if (sb_reserve_en && sb_reserve_addr != 3'd7) m_pend[sb_reserve_addr] = 1'b1;
         if (r7_write_en) begin
            m_r7_b = d_R7_in;
            m_r7_n = d_R7_in;
         end
      end
      @(negedge clk);
   endtask

   initial begin
      for (int i = 0; i < 8; i++) begin
         m_reg[i] = 16'hxxxx;
         m_pend[i] = 1'b0;
      end
      m_r7_b = 16'hxxxx;
      m_r7_n = 16'hxxxx;

      // Reset and read back reset contents
      drive(1, 3'd0, 3'd0, 0, 3'd0, 16'h0, 0, 16'h0, 0, 3'd0);
      tick();
      drive(0, 3'd3, 3'd7, 0, 3'd0, 16'h0, 0, 16'h0, 0, 3'd0);
      check_all();
      check("rst_d1", d1_b, 16'h0000);
      check("rst_pc", pc_b, 16'h0000);
      check("rst_busy", {14'd0, busy1_b, busy2_b}, 16'd0);
      check("rst_pc_param", pc_n, 16'hA5C3);
      tick();

      // GPR write with same-cycle forwarding
      drive(0, 3'd2, 3'd2, 1, 3'd2, 16'hBEEF, 0, 16'h0, 0, 3'd0);
      check_all();
      check("fwd_d1", d1_b, 16'hBEEF);
      check("nofwd_d1", d1_n, 16'h0000);
      tick();
      drive(0, 3'd2, 3'd0, 0, 3'd2, 16'h0, 0, 16'h0, 0, 3'd0);
      check_all();
      check("stored_d1", d1_b, 16'hBEEF);
      check("stored_d1_nobyp", d1_n, 16'hBEEF);
      tick();

      // R7 load together with an ignored GPR write to address 7
      drive(0, 3'd7, 3'd7, 1, 3'd7, 16'hFFFF, 1, 16'h0010, 0, 3'd0);
      check_all();
      check("r7_no_fwd", d1_b, 16'h0000);
      tick();
      drive(0, 3'd7, 3'd0, 0, 3'd0, 16'h0, 0, 16'h0, 0, 3'd0);
      check_all();
      check("pc_loaded", pc_b, 16'h0010);
      check("r7_read", d1_b, 16'h0010);
      tick();

      // Reserve R5, then retire it
      drive(0, 3'd5, 3'd0, 0, 3'd0, 16'h0, 0, 16'h0, 1, 3'd5);
      check_all();
      tick();
      drive(0, 3'd5, 3'd0, 0, 3'd0, 16'h0, 0, 16'h0, 0, 3'd0);
      check_all();
      check("r5_busy", {15'd0, busy1_b}, 16'd1);
      tick();
      drive(0, 3'd5, 3'd5, 1, 3'd5, 16'h1234, 0, 16'h0, 0, 3'd0);
      check_all();
      check("r5_busy_masked", {15'd0, busy1_b}, 16'd0);
      check("r5_busy_nobyp", {15'd0, busy1_n}, 16'd1);
      tick();
      drive(0, 3'd5, 3'd0, 0, 3'd0, 16'h0, 0, 16'h0, 0, 3'd0);
      check_all();
      check("r5_retired", {15'd0, busy1_b}, 16'd0);
      check("r5_data", d1_b, 16'h1234);
      tick();

      // Simultaneous reserve and write-back of R4
      drive(0, 3'd4, 3'd0, 1, 3'd4, 16'h4444, 0, 16'h0, 1, 3'd4);
      check_all();
      tick();
      drive(0, 3'd4, 3'd0, 0, 3'd0, 16'h0, 0, 16'h0, 0, 3'd0);
      check_all();
      check("r4_set_wins", {15'd0, busy1_b}, 16'd1);
      check("r4_data", d1_b, 16'h4444);
      tick();
      drive(0, 3'd4, 3'd4, 1, 3'd4, 16'h5555, 0, 16'h0, 1, 3'd4);
      check_all();
      check("r4_reserve_unmasked", {15'd0, busy1_b}, 16'd1);
      tick();
      drive(0, 3'd7, 3'd0, 0, 3'd0, 16'h0, 0, 16'h0, 1, 3'd7);
      check_all();
      tick();
      drive(0, 3'd7, 3'd0, 0, 3'd0, 16'h0, 0, 16'h0, 0, 3'd0);
      check_all();
      check("r7_never_busy", {15'd0, busy1_b}, 16'd0);
      tick();

      // Reset while R1 is pending and being written
      drive(0, 3'd1, 3'd0, 0, 3'd0, 16'h0, 0, 16'h0, 1, 3'd1);
      tick();
      drive(1, 3'd1, 3'd1, 1, 3'd1, 16'h7777, 1, 16'h9999, 1, 3'd1);
      tick();
      drive(0, 3'd1, 3'd1, 0, 3'd0, 16'h0, 0, 16'h0, 0, 3'd0);
      check_all();
      check("rst_mid_r1", d1_b, 16'h0000);
      check("rst_mid_busy", {15'd0, busy1_b}, 16'd0);
      check("rst_mid_pc", pc_n, 16'hA5C3);
      tick();

      // Randomised traffic with occasional resets
      for (int n = 0; n < 400; n++) begin
         drive(($urandom_range(0, 39) == 0),
               3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)),
               ($urandom_range(0, 2) != 0), 3'($urandom_range(0, 7)), 16'($urandom),
               ($urandom_range(0, 3) == 0), 16'($urandom),
               ($urandom_range(0, 1) == 1), 3'($urandom_range(0, 7)));
         check_all();
         tick();
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
